mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS core. It sits directly upstream of the datapath and drives every datapath select and enable.
- Inputs are the opcode/funct of the selected instruction word, the ALU multicycle stall, and the ALU result LSB (branch condition).
- One instruction is sequenced through fetch, decode, execute, memory and writeback states.

Parameters:
- FETCH_PC_INC, 4, byte increment selected via ALUSrcB=01 (documentation only; the datapath constant is fixed).
- ILLEGAL_TRAP, 0, 1 = halt in ILLEGAL state on unknown opcode; 0 = skip the instruction and return to FETCH.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- opcode  in  6  Instr[31:26] from the datapath.
- funct  in  6  Instr[5:0].
- stall  in  1  ALU multicycle op (mult/div) busy.
- OUTLSB  in  1  aluoutnext[0]; branch condition.
- PcEn, IorD, IrWrite, IrSel, RegDst, MemToReg, RegWrite, ALUSrcA, ExtSel, ALUsel, PCSrc, MemWrite  out  1 each  datapath controls.
- ALUSrcB  out  2  srcb select: 00 reg B, 01 const 4, 10 imm, 11 imm<<2.
- ALUControl  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1000 seq, 1111 R-type (ALU decodes funct).
- illegal  out  1  unknown opcode seen.

Behaviour:
- Moore FSM; all outputs decode from the state register only, except PcEn in BRANCH (depends on OUTLSB).
- Any output not listed for a state is 0.
- Reset: reset=0 at a clk edge forces state RST. RST drives all outputs 0 and illegal=0. This applies mid-instruction too: an in-flight instruction is abandoned and nothing further is written.
- RST -> FETCH on the first edge with reset=1.
- FETCH:
  - Outputs: IorD=0, IrWrite=1, IrSel=0, ALUSrcA=0, ALUSrcB=01, ALUControl=0010, ALUsel=0, PCSrc=0, PcEn=1.
  - Next state: DECODE.
- DECODE:
  - Outputs: IrSel=1, ALUSrcA=0, ALUSrcB=11, ALUControl=0010, ExtSel=0. This latches the branch target into the ALU register.
  - Next state by opcode:
    - 0x00 -> EXEC_R
    - 0x23/0x2B -> MEMADR
    - 0x04/0x05 -> BRANCH
    - 0x08/0x09/0x0A/0x0C/0x0D -> EXEC_I
    - else -> ILLEGAL
- EXEC_R:
  - Outputs: IrSel=1, ALUSrcA=1, ALUSrcB=00, ALUControl=1111.
  - Holds while stall=1. Leaves for ALUWB on the first edge with stall=0.
  - A stall of N cycles adds exactly N cycles.
- ALUWB: IrSel=1, RegDst=1, MemToReg=1, ALUsel=1, RegWrite=1 -> FETCH.
- EXEC_I:
  - Outputs: IrSel=1, ALUSrcA=1, ALUSrcB=10.
  - ExtSel=1 for 0x0C/0x0D, else 0.
  - ALUControl: add for 0x08/0x09, slt for 0x0A, and for 0x0C, or for 0x0D.
  - Next state: IMMWB.
- IMMWB: IrSel=1, RegDst=0, MemToReg=1, ALUsel=1, RegWrite=1; controls as in EXEC_I held -> FETCH.
- MEMADR: IrSel=1, ALUSrcA=1, ALUSrcB=10, ALUControl=0010, ExtSel=0 -> MEMRD (lw) or MEMWR (sw).
- MEMRD: IrSel=1, IorD=1, ALUsel=1 -> MEMWB.
- MEMWB: IrSel=1, RegDst=0, MemToReg=0, RegWrite=1 -> FETCH. The load word enters via irin.
- MEMWR: IrSel=1, IorD=1, ALUsel=1, MemWrite=1 -> FETCH.
- BRANCH:
  - Outputs: IrSel=1, ALUSrcA=1, ALUSrcB=00, ALUControl=1000, ALUsel=1, PCSrc=0.
  - PcEn = OUTLSB for beq, ~OUTLSB for bne.
  - Next state: FETCH.
- ILLEGAL: illegal=1 (sticky until reset).
  - ILLEGAL_TRAP=0: -> FETCH with no register or memory write.
  - ILLEGAL_TRAP=1: stay in ILLEGAL with all enables 0.
- stall in any state other than EXEC_R is ignored.
- CPI: lw 5, sw 4, R 4+stall, I-type 4, branch 3.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- When defined:
  - Adds outputs cycle_cnt[31:0] and instr_cnt[31:0], both 0 in RST.
  - cycle_cnt increments every non-RST cycle.
  - instr_cnt increments on each exit to FETCH from ALUWB, IMMWB, MEMWB, MEMWR or BRANCH.
  - Both counters wrap 0xFFFFFFFF -> 0.
- When undefined: ports absent, no counter logic.

Test Plan:
- Reset low 3 cycles mid-EXEC_R, then high -> outputs all 0 during reset; FETCH (IrWrite=1, PcEn=1) on the 2nd cycle after release; RegWrite never pulses for the aborted op.
- opcode 0x23 -> state trace FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 with MemToReg=0 only in cycle 5; IorD=1 only in cycle 4.
- opcode 0x00, stall high 3 cycles in EXEC_R -> EXEC_R lasts 4 cycles; ALUWB with RegDst=1 and RegWrite=1 follows; total 7 cycles.
- opcode 0x04 with OUTLSB=1, then with OUTLSB=0 -> PcEn=1, then PcEn=0, in the BRANCH cycle; opcode 0x05 inverts both.
- opcode 0x0D -> EXEC_I with ExtSel=1 and ALUControl=0001; IMMWB with RegWrite=1 and RegDst=0.
- opcode 0x3F, ILLEGAL_TRAP=0 -> illegal=1 from the 3rd cycle onward; back in FETCH in the 4th cycle; no RegWrite/MemWrite pulse. With CTRL_PERF_CNT_EN, an 8-instruction program gives instr_cnt=8.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS main control FSM (optional perf counters: CTRL_PERF_CNT_EN)
module mips_multicycle_ctrl #(
    parameter int FETCH_PC_INC = 4,
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       stall,
    input  logic       OUTLSB,
    output logic       PcEn,
    output logic       IorD,
    output logic       IrWrite,
    output logic       IrSel,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       ExtSel,
    output logic       ALUsel,
    output logic       PCSrc,
    output logic       MemWrite,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic       illegal
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_ALUWB, S_EXEC_I, S_IMMWB,
        S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_ILLEGAL
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SEQ = 4'b1000;
    localparam logic [3:0] ALU_R   = 4'b1111;

    state_t     state, state_next;
    logic [3:0] imm_alu, imm_alu_dec;
    logic       imm_ext, is_bne, illegal_q;

    // funct is decoded by the ALU itself; the PC increment constant lives in the datapath
    logic unused_ok;
    assign unused_ok = ^{funct, FETCH_PC_INC[0]};

    always_comb begin
        imm_alu_dec = ALU_ADD;
        case (opcode)
            6'h0A:   imm_alu_dec = ALU_SLT;
            6'h0C:   imm_alu_dec = ALU_AND;
            6'h0D:   imm_alu_dec = ALU_OR;
            default: imm_alu_dec = ALU_ADD;
        endcase
    end

    // Per-instruction attributes are captured in DECODE so later states decode from registers only
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_RST;
            imm_alu   <= ALU_ADD;
            imm_ext   <= 1'b0;
            is_bne    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                imm_alu <= imm_alu_dec;
                imm_ext <= (opcode == 6'h0C) || (opcode == 6'h0D);
                is_bne  <= (opcode == 6'h05);
            end
            if (state == S_ILLEGAL)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        PcEn = 1'b0; IorD = 1'b0; IrWrite = 1'b0; IrSel = 1'b0;
        RegDst = 1'b0; MemToReg = 1'b0; RegWrite = 1'b0; ALUSrcA = 1'b0;
        ExtSel = 1'b0; ALUsel = 1'b0; PCSrc = 1'b0; MemWrite = 1'b0;
        ALUSrcB = 2'b00; ALUControl = 4'b0000;
        illegal = illegal_q;
        case (state)
            S_RST: state_next = S_FETCH;
            S_FETCH: begin
                IrWrite = 1'b1; ALUSrcB = 2'b01; ALUControl = ALU_ADD; PcEn = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                IrSel = 1'b1; ALUSrcB = 2'b11; ALUControl = ALU_ADD;
                case (opcode)
                    6'h00:                             state_next = S_EXEC_R;
                    6'h23, 6'h2B:                      state_next = S_MEMADR;
                    6'h04, 6'h05:                      state_next = S_BRANCH;
                    6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D: state_next = S_EXEC_I;
                    default:                           state_next = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                IrSel = 1'b1; ALUSrcA = 1'b1; ALUControl = ALU_R;
                if (!stall)
                    state_next = S_ALUWB;
            end
            S_ALUWB: begin
                IrSel = 1'b1; RegDst = 1'b1; MemToReg = 1'b1; ALUsel = 1'b1; RegWrite = 1'b1;
                state_next = S_FETCH;
            end
            S_EXEC_I: begin
                IrSel = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10;
                ExtSel = imm_ext; ALUControl = imm_alu;
                state_next = S_IMMWB;
            end
            S_IMMWB: begin
                IrSel = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10;
                ExtSel = imm_ext; ALUControl = imm_alu;
                MemToReg = 1'b1; ALUsel = 1'b1; RegWrite = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMADR: begin
                IrSel = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUControl = ALU_ADD;
                state_next = (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IrSel = 1'b1; IorD = 1'b1; ALUsel = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                IrSel = 1'b1; RegWrite = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                IrSel = 1'b1; IorD = 1'b1; ALUsel = 1'b1; MemWrite = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                IrSel = 1'b1; ALUSrcA = 1'b1; ALUControl = ALU_SEQ; ALUsel = 1'b1;
                PcEn = OUTLSB ^ is_bne;
                state_next = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                state_next = ILLEGAL_TRAP ? S_ILLEGAL : S_FETCH;
            end
            default: state_next = S_RST;
        endcase
    end

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            if (state != S_RST)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (state inside {S_ALUWB, S_IMMWB, S_MEMWB, S_MEMWR, S_BRANCH})
                instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset, stall, OUTLSB;
    logic [5:0] opcode, funct;
    logic       PcEn, IorD, IrWrite, IrSel, RegDst, MemToReg, RegWrite, ALUSrcA;
    logic       ExtSel, ALUsel, PCSrc, MemWrite, illegal;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUControl;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .stall(stall), .OUTLSB(OUTLSB),
        .PcEn(PcEn), .IorD(IorD), .IrWrite(IrWrite), .IrSel(IrSel), .RegDst(RegDst),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ExtSel(ExtSel),
        .ALUsel(ALUsel), .PCSrc(PCSrc), .MemWrite(MemWrite), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .illegal(illegal)
`ifdef CTRL_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // {PcEn,IorD,IrWrite,IrSel,RegDst,MemToReg,RegWrite,ALUSrcA,ExtSel,ALUsel,PCSrc,MemWrite, ALUSrcB, ALUControl, illegal}
    logic [18:0] ctrl;
    assign ctrl = {PcEn, IorD, IrWrite, IrSel, RegDst, MemToReg, RegWrite, ALUSrcA, ExtSel,
                   ALUsel, PCSrc, MemWrite, ALUSrcB, ALUControl, illegal};

    localparam logic [18:0] E_FETCH  = {12'b1_0_1_0_0_0_0_0_0_0_0_0, 2'b01, 4'b0010, 1'b0};
    localparam logic [18:0] E_DECODE = {12'b0_0_0_1_0_0_0_0_0_0_0_0, 2'b11, 4'b0010, 1'b0};
    localparam logic [18:0] E_EXECR  = {12'b0_0_0_1_0_0_0_1_0_0_0_0, 2'b00, 4'b1111, 1'b0};
    localparam logic [18:0] E_ALUWB  = {12'b0_0_0_1_1_1_1_0_0_1_0_0, 2'b00, 4'b0000, 1'b0};
    localparam logic [18:0] E_EXECI  = {12'b0_0_0_1_0_0_0_1_1_0_0_0, 2'b10, 4'b0001, 1'b0};
    localparam logic [18:0] E_IMMWB  = {12'b0_0_0_1_0_1_1_1_1_1_0_0, 2'b10, 4'b0001, 1'b0};
    localparam logic [18:0] E_MEMADR = {12'b0_0_0_1_0_0_0_1_0_0_0_0, 2'b10, 4'b0010, 1'b0};
    localparam logic [18:0] E_MEMRD  = {12'b0_1_0_1_0_0_0_0_0_1_0_0, 2'b00, 4'b0000, 1'b0};
    localparam logic [18:0] E_MEMWB  = {12'b0_0_0_1_0_0_1_0_0_0_0_0, 2'b00, 4'b0000, 1'b0};
    localparam logic [18:0] E_MEMWR  = {12'b0_1_0_1_0_0_0_0_0_1_0_1, 2'b00, 4'b0000, 1'b0};
    localparam logic [18:0] E_BR_NT  = {12'b0_0_0_1_0_0_0_1_0_1_0_0, 2'b00, 4'b1000, 1'b0};
    localparam logic [18:0] E_BR_T   = {12'b1_0_0_1_0_0_0_1_0_1_0_0, 2'b00, 4'b1000, 1'b0};
    localparam logic [18:0] E_ILL    = 19'h00001;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic rw_seen;
        reset = 1'b0; opcode = 6'h00; funct = 6'h20; stall = 1'b0; OUTLSB = 1'b0;
        tick(); tick();
        checks++;
        if (ctrl !== 19'h0) begin errors++; $display("FAIL reset_rst: got %h expected %h", ctrl, 19'h0); end
        reset = 1'b1;
        checks++;
        if (ctrl !== 19'h0) begin errors++; $display("FAIL reset_release_c1: got %h expected %h", ctrl, 19'h0); end
        tick();
        checks++;
        if (ctrl !== E_FETCH) begin errors++; $display("FAIL reset_release_fetch: got %h expected %h", ctrl, E_FETCH); end
        tick();
        stall = 1'b1;
        tick();
        checks++;
        if (ctrl !== E_EXECR) begin errors++; $display("FAIL reset_exec_r: got %h expected %h", ctrl, E_EXECR); end
        reset = 1'b0;
        rw_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            rw_seen |= RegWrite;
            checks++;
            if (ctrl !== 19'h0) begin errors++; $display("FAIL reset_mid_c%0d: got %h expected %h", i, ctrl, 19'h0); end
        end
        reset = 1'b1; stall = 1'b0;
        rw_seen |= RegWrite;
        tick();
        checks++;
        if (rw_seen !== 1'b0) begin errors++; $display("FAIL reset_abort_regwrite: got %b expected 0", rw_seen); end
        checks++;
        if (ctrl !== E_FETCH) begin errors++; $display("FAIL reset_mid_fetch: got %h expected %h", ctrl, E_FETCH); end
    endtask

    task automatic test_lw();
        logic [18:0] exp [6];
        exp = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
        opcode = 6'h23;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (ctrl !== exp[i]) begin errors++; $display("FAIL lw_c%0d: got %h expected %h", i, ctrl, exp[i]); end
            if (i < 5) tick();
        end
    endtask

    task automatic test_sw();
        logic [18:0] exp [5];
        exp = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_FETCH};
        opcode = 6'h2B;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ctrl !== exp[i]) begin errors++; $display("FAIL sw_c%0d: got %h expected %h", i, ctrl, exp[i]); end
            if (i < 4) tick();
        end
    endtask

    task automatic test_rtype_stall();
        logic [18:0] exp [8];
        logic        stl [8];
        exp = '{E_FETCH, E_DECODE, E_EXECR, E_EXECR, E_EXECR, E_EXECR, E_ALUWB, E_FETCH};
        stl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        opcode = 6'h00;
        for (int i = 0; i < 8; i++) begin
            stall = stl[i];
            checks++;
            if (ctrl !== exp[i]) begin errors++; $display("FAIL rtype_c%0d: got %h expected %h", i, ctrl, exp[i]); end
            if (i < 7) tick();
        end
        stall = 1'b0;
    endtask

    task automatic test_branch();
        logic [5:0]  ops [4];
        logic        lsb [4];
        logic [18:0] eb  [4];
        ops = '{6'h04, 6'h04, 6'h05, 6'h05};
        lsb = '{1'b1, 1'b0, 1'b1, 1'b0};
        eb  = '{E_BR_T, E_BR_NT, E_BR_NT, E_BR_T};
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k]; OUTLSB = lsb[k];
            tick();
            checks++;
            if (ctrl !== E_DECODE) begin errors++; $display("FAIL br%0d_decode: got %h expected %h", k, ctrl, E_DECODE); end
            tick();
            checks++;
            if (ctrl !== eb[k]) begin errors++; $display("FAIL br%0d_branch: got %h expected %h", k, ctrl, eb[k]); end
            tick();
            checks++;
            if (ctrl !== E_FETCH) begin errors++; $display("FAIL br%0d_fetch: got %h expected %h", k, ctrl, E_FETCH); end
        end
        OUTLSB = 1'b0;
    endtask

    task automatic test_ori();
        logic [18:0] exp [5];
        exp = '{E_FETCH, E_DECODE, E_EXECI, E_IMMWB, E_FETCH};
        opcode = 6'h0D;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ctrl !== exp[i]) begin errors++; $display("FAIL ori_c%0d: got %h expected %h", i, ctrl, exp[i]); end
            if (i < 4) tick();
        end
    endtask

    task automatic test_illegal();
        logic [18:0] exp [5];
        exp = '{E_FETCH, E_DECODE, E_ILL, E_FETCH | 19'h1, E_DECODE | 19'h1};
        opcode = 6'h3F;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) opcode = 6'h04;
            checks++;
            if (ctrl !== exp[i]) begin errors++; $display("FAIL illegal_c%0d: got %h expected %h", i, ctrl, exp[i]); end
            if (i < 4) tick();
        end
        reset = 1'b0;
        tick();
        checks++;
        if (ctrl !== 19'h0) begin errors++; $display("FAIL illegal_cleared: got %h expected %h", ctrl, 19'h0); end
        reset = 1'b1;
        tick();
        checks++;
        if (ctrl !== E_FETCH) begin errors++; $display("FAIL illegal_refetch: got %h expected %h", ctrl, E_FETCH); end
    endtask

`ifdef CTRL_PERF_CNT_EN
    task automatic test_perf();
        logic [5:0] ops [8];
        int         cpi [8];
        ops = '{6'h23, 6'h2B, 6'h00, 6'h0D, 6'h04, 6'h08, 6'h05, 6'h00};
        cpi = '{5, 4, 4, 4, 3, 4, 3, 4};
        reset = 1'b0; stall = 1'b0; OUTLSB = 1'b1;
        tick();
        checks++;
        if ({cycle_cnt, instr_cnt} !== 64'h0) begin errors++; $display("FAIL perf_reset: got %h/%h expected 0/0", cycle_cnt, instr_cnt); end
        reset = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            opcode = ops[k];
            repeat (cpi[k]) tick();
        end
        checks++;
        if (instr_cnt !== 32'd8) begin errors++; $display("FAIL perf_instr: got %0d expected 8", instr_cnt); end
        checks++;
        if (cycle_cnt !== 32'd31) begin errors++; $display("FAIL perf_cycle: got %0d expected 31", cycle_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype_stall();
        test_branch();
        test_ori();
        test_illegal();
`ifdef CTRL_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
